// File: rtl/mem_responder.sv
// Stallable single-outstanding memory target: valid/ready request in, one-cycle response out.
// Define MEM_RESP_ALIGN_CHECK_EN to fault word accesses whose addr[1:0] is nonzero.
module mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);
    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  WS_LOAD    = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
`ifdef MEM_RESP_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        write_q, write_d;
    logic        byte_q, byte_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          commit;
    logic          fault;
    logic          mem_we;
    logic          cur_write;
    logic          cur_byte;
    logic [31:0]   cur_addr;
    logic [31:0]   cur_wdata;
    logic [AW-1:0] widx;
    logic [1:0]    lane;
    logic [31:0]   word_rd;
    logic [31:0]   word_wr;
    logic [7:0]    byte_rd;

    // With zero wait states the commit happens on the accepting edge, so use the live request.
    always_comb begin
        if (state_q == S_IDLE) begin
            cur_write = req_write;
            cur_byte  = req_byte;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
        end else begin
            cur_write = write_q;
            cur_byte  = byte_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end
    end

    always_comb begin
        widx    = cur_addr[AW+1:2];
        lane    = cur_addr[1:0];
        fault   = (cur_addr >= ADDR_LIMIT) || (ALIGN_CHECK && !cur_byte && (lane != 2'd0));
        word_rd = mem[widx];
        byte_rd = word_rd[{lane, 3'b000} +: 8];
        word_wr = cur_wdata;
        if (cur_byte) begin
            word_wr = word_rd;
            word_wr[{lane, 3'b000} +: 8] = cur_wdata[7:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        write_d   = write_q;
        byte_d    = byte_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        commit    = 1'b0;
        req_ready = (state_q == S_IDLE);
        accept    = req_valid && req_ready;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    write_d = req_write;
                    byte_d  = req_byte;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WS_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (commit) begin
            err_d   = fault;
            rdata_d = 32'd0;
            if (!fault && !cur_write) begin
                rdata_d = cur_byte ? {24'd0, byte_rd} : word_rd;
            end
        end
    end

    // A store is dropped if reset is held on what would have been its commit edge.
    assign mem_we = commit && cur_write && !fault && reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        write_q <= write_d;
        byte_q  <= byte_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[widx] <= word_wr;
        end
    end

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: instance 0 uses two wait states, instance 1 uses none.
// A transaction-level model predicts every output each cycle; per-response literals pin the model.
module tb_mem_responder;
    localparam int DEPTH = 256;
    localparam int NPIN  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [2];
    logic        rv    [2];
    logic        rw    [2];
    logic        rb    [2];
    logic [31:0] ra    [2];
    logic [31:0] rd    [2];
    logic        rdy   [2];
    logic        vld   [2];
    logic [31:0] rdat  [2];
    logic        err   [2];
    logic        bsy   [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_responder #(
            .DEPTH_WORDS(DEPTH),
            .WAIT_STATES((g == 0) ? 2 : 0)
        ) u_dut (
            .clk      (clk),
            .reset    (rst_n[g]),
            .req_valid(rv[g]),
            .req_ready(rdy[g]),
            .req_write(rw[g]),
            .req_byte (rb[g]),
            .req_addr (ra[g]),
            .req_wdata(rd[g]),
            .rsp_valid(vld[g]),
            .rsp_rdata(rdat[g]),
            .rsp_err  (err[g]),
            .busy     (bsy[g])
        );
    end

    function automatic int ws_of(input int g);
        return (g == 0) ? 2 : 0;
    endfunction

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state: one pending request, the cycle it was accepted, and the response it will give.
    bit          m_pend  [2];
    bit          m_resp  [2];
    int          m_acc   [2];
    logic        m_w     [2];
    logic        m_b     [2];
    logic [31:0] m_a     [2];
    logic [31:0] m_d     [2];
    logic [31:0] m_rdata [2];
    logic        m_err   [2];
    bit          m_known [2];
    logic [31:0] mdl_mem   [2][DEPTH];
    bit          mdl_known [2][DEPTH];
    int          obs_acc [2];
    int          rcnt    [2];

    // Hand-computed per-response expectations, filled by the stimulus.
    logic [31:0] pin_rdata [2][NPIN];
    logic        pin_err   [2][NPIN];
    int          pin_lat   [2][NPIN];
    int          npin      [2];
    int          tmo_cnt  = 0;
    int          tmo_seen = 0;

    task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] cycle %0d: got %h, expected %h", name, g, cyc, act, exp);
        end
    endtask

    task automatic model_commit(input int g);
        int          idx;
        int          sh;
        bit          bad;
        logic [31:0] word;
        idx = int'(m_a[g] >> 2) % DEPTH;
        sh  = int'(m_a[g] % 4) * 8;
        bad = (m_a[g] >= 32'(DEPTH * 4));
`ifdef MEM_RESP_ALIGN_CHECK_EN
        if (!m_b[g] && (m_a[g] % 4 != 0)) bad = 1'b1;
`endif
        m_rdata[g] = 32'd0;
        m_err[g]   = bad;
        m_known[g] = 1'b1;
        if (!bad) begin
            word = mdl_mem[g][idx];
            if (m_w[g]) begin
                if (m_b[g]) begin
                    word = (word & ~(32'hFF << sh)) | ({24'd0, m_d[g][7:0]} << sh);
                end else begin
                    word = m_d[g];
                    mdl_known[g][idx] = 1'b1;
                end
                mdl_mem[g][idx] = word;
            end else begin
                m_known[g] = mdl_known[g][idx];
                m_rdata[g] = m_b[g] ? ((word >> sh) & 32'hFF) : word;
            end
        end
        m_resp[g] = 1'b1;
        m_pend[g] = 1'b0;
    endtask

    always @(negedge clk) begin
        cyc++;
        for (int g = 0; g < 2; g++) begin
            if (!rst_n[g]) begin
                m_pend[g]  = 1'b0;
                m_resp[g]  = 1'b0;
                m_rdata[g] = 32'd0;
                m_err[g]   = 1'b0;
                m_known[g] = 1'b1;
            end
            check("req_ready", g, 32'(rdy[g]), 32'(!(m_pend[g] || m_resp[g])));
            check("busy", g, 32'(bsy[g]), 32'(m_pend[g] || m_resp[g]));
            check("rsp_valid", g, 32'(vld[g]), 32'(m_resp[g]));
            check("rsp_err", g, 32'(err[g]), 32'(m_err[g]));
            if (m_known[g]) check("rsp_rdata", g, rdat[g], m_rdata[g]);
            if (vld[g] === 1'b1) begin
                if (rcnt[g] < npin[g]) begin
                    check("pin_rdata", g, rdat[g], pin_rdata[g][rcnt[g]]);
                    check("pin_err", g, 32'(err[g]), 32'(pin_err[g][rcnt[g]]));
                    check("pin_latency", g, 32'(cyc - obs_acc[g]), 32'(pin_lat[g][rcnt[g]]));
                end
                rcnt[g]++;
            end
            if (rst_n[g] && rv[g] && rdy[g]) obs_acc[g] = cyc;
            // Predict the effect of the coming rising edge.
            if (rst_n[g]) begin
                if (m_resp[g]) begin
                    m_resp[g] = 1'b0;
                end else if (!m_pend[g] && rv[g]) begin
                    m_pend[g] = 1'b1;
                    m_acc[g]  = cyc;
                    m_w[g]    = rw[g];
                    m_b[g]    = rb[g];
                    m_a[g]    = ra[g];
                    m_d[g]    = rd[g];
                end
                if (m_pend[g] && (cyc == m_acc[g] + ws_of(g))) model_commit(g);
            end
        end
        if (tmo_cnt != tmo_seen) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout cycle %0d: got %0d timeouts, expected 0", cyc, tmo_cnt);
            tmo_seen = tmo_cnt;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic add_pin(input int g, input logic [31:0] prd, input logic perr, input int plat);
        pin_rdata[g][npin[g]] = prd;
        pin_err[g][npin[g]]   = perr;
        pin_lat[g][npin[g]]   = plat;
        npin[g]++;
    endtask

    task automatic set_req(input int g, input logic w, input logic b, input logic [31:0] a, input logic [31:0] d);
        rw[g] = w;
        rb[g] = b;
        ra[g] = a;
        rd[g] = d;
    endtask

    task automatic wait_accept(input int g);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (rdy[g] === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!ok) tmo_cnt++;
    endtask

    task automatic do_req(input int g, input logic w, input logic b, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] prd, input logic perr);
        add_pin(g, prd, perr, ws_of(g) + 1);
        set_req(g, w, b, a, d);
        rv[g] = 1'b1;
        wait_accept(g);
        rv[g] = 1'b0;
        idle(3);
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            rst_n[g] = 1'b0;
            rv[g]    = 1'b0;
            npin[g]  = 0;
            rcnt[g]  = 0;
            set_req(g, 1'b0, 1'b0, 32'd0, 32'd0);
        end
        idle(3);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        idle(2);

        // Word store/load round trip.
        do_req(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        do_req(0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // Byte lanes.
        do_req(0, 1'b1, 1'b0, 32'h20, 32'h11223344, 32'h0, 1'b0);
        do_req(0, 1'b1, 1'b1, 32'h22, 32'hFFFFFFAA, 32'h0, 1'b0);
        do_req(0, 1'b0, 1'b0, 32'h20, 32'h0, 32'h11AA3344, 1'b0);
        do_req(0, 1'b0, 1'b1, 32'h23, 32'h0, 32'h00000011, 1'b0);

        // Out of range must not alias onto word 0.
        do_req(0, 1'b1, 1'b0, 32'h000, 32'hCAFEF00D, 32'h0, 1'b0);
        do_req(0, 1'b1, 1'b0, 32'h400, 32'h12345678, 32'h0, 1'b1);
        do_req(0, 1'b0, 1'b0, 32'h000, 32'h0, 32'hCAFEF00D, 1'b0);
        do_req(0, 1'b1, 1'b0, 32'h3FC, 32'h0BADC0DE, 32'h0, 1'b0);
        do_req(0, 1'b0, 1'b1, 32'h3FF, 32'h0, 32'h0000000B, 1'b0);

        // Misaligned word load.
`ifdef MEM_RESP_ALIGN_CHECK_EN
        do_req(0, 1'b0, 1'b0, 32'h21, 32'h0, 32'h0, 1'b1);
`else
        do_req(0, 1'b0, 1'b0, 32'h21, 32'h0, 32'h11AA3344, 1'b0);
`endif

        // Back-to-back with req_valid held; the request shown during WAIT must be ignored.
        add_pin(0, 32'h0, 1'b0, 3);
        add_pin(0, 32'h01020304, 1'b0, 3);
        set_req(0, 1'b1, 1'b0, 32'h40, 32'h01020304);
        rv[0] = 1'b1;
        wait_accept(0);
        set_req(0, 1'b1, 1'b0, 32'h40, 32'hFFFFFFFF);
        idle(1);
        set_req(0, 1'b0, 1'b0, 32'h40, 32'h0);
        wait_accept(0);
        rv[0] = 1'b0;
        idle(3);

        // Reset during WAIT abandons the store.
        do_req(0, 1'b1, 1'b0, 32'h30, 32'h0, 32'h0, 1'b0);
        set_req(0, 1'b1, 1'b0, 32'h30, 32'h00000055);
        rv[0] = 1'b1;
        wait_accept(0);
        rv[0] = 1'b0;
        rst_n[0] = 1'b0;
        idle(2);
        rst_n[0] = 1'b1;
        idle(2);
        do_req(0, 1'b0, 1'b0, 32'h30, 32'h0, 32'h0, 1'b0);

        // Zero wait states: response in the cycle after acceptance.
        do_req(1, 1'b1, 1'b0, 32'h8, 32'hA5A5A5A5, 32'h0, 1'b0);
        do_req(1, 1'b0, 1'b0, 32'h8, 32'h0, 32'hA5A5A5A5, 1'b0);
        do_req(1, 1'b1, 1'b1, 32'h9, 32'h0000003C, 32'h0, 1'b0);
        do_req(1, 1'b0, 1'b0, 32'h8, 32'h0, 32'hA5A53CA5, 1'b0);
        do_req(1, 1'b0, 1'b1, 32'h400, 32'h0, 32'h0, 1'b1);
`ifdef MEM_RESP_ALIGN_CHECK_EN
        do_req(1, 1'b0, 1'b0, 32'hA, 32'h0, 32'h0, 1'b1);
`else
        do_req(1, 1'b0, 1'b0, 32'hA, 32'h0, 32'hA5A53CA5, 1'b0);
`endif

        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
